alu_32_issuer: RTL

Sequential initiator that feeds the combinational 32-bit ALU (`A`, `B`, `Cond` → `Z`) from a command stream and returns its results. It accepts one command over a valid/ready handshake, drives registered operands into the ALU, waits a programmable settle time, captures `Z`, and holds a tagged response until the consumer takes it. It sits between the instruction/control logic and the ALU, and is the only driver of the ALU's input ports.

---
 rtl/alu_32_issuer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_32_issuer.sv
// alu_32_issuer: sequential initiator for a combinational 32-bit ALU.
// It accepts one command over valid/ready and drives registered operands into
// the ALU. It waits SETTLE extra cycles, captures Z into a tagged response and
// holds that response until the consumer takes it. Only one command is in
// flight at a time.
//
// Optional feature: define ALU_32_ISSUER_FLAGS_EN to add the registered
// rsp_zero / rsp_neg result flags. The default build leaves them out.
//
// Parameters:
//   SETTLE : extra cycles the ALU inputs are held before Z is sampled (0..15)
//   TAG_W  : width of the response sequence tag

module alu_32_issuer #(
   parameter int SETTLE = 1,
   parameter int TAG_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   // command side
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [3:0]       cmd_cond,
   // ALU side
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [3:0]       alu_cond,
   input  logic [31:0]      alu_z,
   // response side
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_z,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
`ifdef ALU_32_ISSUER_FLAGS_EN
   ,
   output logic             rsp_zero,
   output logic             rsp_neg
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   // Opcodes whose zero divisor makes the ALU result meaningless.
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_MOD = 4'b0100;

   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic             r_err_pend;
   logic [31:0]      r_alu_a;
   logic [31:0]      r_alu_b;
   logic [3:0]       r_alu_cond;
   logic [31:0]      r_rsp_z;
   logic             r_rsp_err;
   logic             r_rsp_valid;
   logic [TAG_W-1:0] r_rsp_tag;
`ifdef ALU_32_ISSUER_FLAGS_EN
   logic             r_rsp_zero;
   logic             r_rsp_neg;
`endif

   logic             w_accept;
   logic             w_div_zero;
   logic [31:0]      w_capture_z;

   // A command is taken only while idle; cmd_valid elsewhere simply waits.
   assign w_accept    = cmd_valid && (r_state == S_IDLE);
   assign w_div_zero  = ((cmd_cond == OP_DIV) || (cmd_cond == OP_MOD)) && (cmd_b == 32'd0);
   // A zero divisor forces the all-ones error pattern and ignores the ALU result.
   assign w_capture_z = r_err_pend ? 32'hFFFF_FFFF : alu_z;

   // Issue FSM: accept, hold the operands for the settle time, capture, then hand off.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before the edge, whatever order the statements run in.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the reset is synchronous and clears every register, including
         // the operand drive and the tag, so an in-flight command leaves no trace.
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_err_pend  <= 1'b0;
         r_alu_a     <= 32'd0;
         r_alu_b     <= 32'd0;
         r_alu_cond  <= 4'd0;
         r_rsp_z     <= 32'd0;
         r_rsp_err   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_tag   <= '0;
`ifdef ALU_32_ISSUER_FLAGS_EN
         r_rsp_zero  <= 1'b0;
         r_rsp_neg   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_alu_a    <= cmd_a;
                  r_alu_b    <= cmd_b;
                  r_alu_cond <= cmd_cond;
                  r_cnt      <= SETTLE_L;
                  r_err_pend <= w_div_zero;
                  r_state    <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rsp_z     <= w_capture_z;
                  r_rsp_err   <= r_err_pend;
                  r_rsp_valid <= 1'b1;
`ifdef ALU_32_ISSUER_FLAGS_EN
                  r_rsp_zero  <= (w_capture_z == 32'd0);
                  r_rsp_neg   <= w_capture_z[31];
`endif
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               // The response stays unchanged until the consumer takes it.
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_tag   <= r_rsp_tag + TAG_W'(1);
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_cond  = r_alu_cond;
   assign rsp_valid = r_rsp_valid;
   assign rsp_z     = r_rsp_z;
   assign rsp_err   = r_rsp_err;
   assign rsp_tag   = r_rsp_tag;
`ifdef ALU_32_ISSUER_FLAGS_EN
   assign rsp_zero  = r_rsp_zero;
   assign rsp_neg   = r_rsp_neg;
`endif

endmodule
